// File: rtl/alu_cond_resolve_pkg.sv
// Shared definitions for the EX/MEM condition resolver: condition-code
// encodings, redirect FSM states and small decode helpers.
package alu_cond_resolve_pkg;

  localparam int unsigned COND_OP_W = 4;
  localparam int unsigned FLAGS_W   = 4;

  typedef enum logic [COND_OP_W-1:0] {
    COND_NONE = 4'd0,
    COND_SEQ  = 4'd1,
    COND_SLT  = 4'd2,
    COND_SLE  = 4'd3,
    COND_SCO  = 4'd4,
    COND_BEQZ = 4'd8,
    COND_BNEZ = 4'd9,
    COND_BLTZ = 4'd10,
    COND_BGEZ = 4'd11
  } cond_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Branch opcodes occupy 8..11, i.e. the top two bits are 2'b10.
  function automatic logic is_branch_op(input logic [COND_OP_W-1:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_cond_resolve_cond_eval.sv
// Combinational condition evaluator: turns the ALU result and flags into a
// set-on-condition value or a branch-taken decision.
module cond_eval
  import alu_cond_resolve_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [COND_OP_W-1:0]  cond_op,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  zf,
  input  logic                  sf,
  input  logic                  of,
  input  logic                  cf,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  taken,
  output logic                  is_branch
);

  // Decode the condition; unlisted encodings behave like NONE (pass-through).
  always_comb begin
    result    = '0;
    taken     = 1'b0;
    is_branch = is_branch_op(cond_op);
    case (cond_op_e'(cond_op))
      COND_NONE: result = alu_out;
      COND_SEQ:  result[0] = zf;
      COND_SLT:  result[0] = sf ^ of;
      COND_SLE:  result[0] = (sf ^ of) | zf;
      COND_SCO:  result[0] = cf;
      COND_BEQZ: taken = zf;
      COND_BNEZ: taken = ~zf;
      COND_BLTZ: taken = sf;
      COND_BGEZ: taken = ~sf;
      default:   result = alu_out;
    endcase
  end

endmodule

// File: rtl/alu_cond_resolve.sv
// EX/MEM condition resolver: registers set-on-condition results and branch
// outcomes, and holds a redirect request to fetch until acknowledged.
module alu_cond_resolve
  import alu_cond_resolve_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [COND_OP_W-1:0]  cond_op,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  zf,
  input  logic                  sf,
  input  logic                  of,
  input  logic                  cf,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic                  wr_en_in,
  input  logic [REG_ADDR_W-1:0] wr_reg_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [FLAGS_W-1:0]    flags_q,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ack
);

  state_e                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0]   wr_reg_q, wr_reg_d;
  logic [FLAGS_W-1:0]      flag_bits_q, flag_bits_d;
  logic [DATA_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;

  logic [DATA_WIDTH-1:0]   ev_result;
  logic                    ev_taken;
  logic                    ev_is_branch;
  logic                    accept;

  cond_eval #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond_eval (
    .cond_op   (cond_op),
    .alu_out   (alu_out),
    .zf        (zf),
    .sf        (sf),
    .of        (of),
    .cf        (cf),
    .result    (ev_result),
    .taken     (ev_taken),
    .is_branch (ev_is_branch)
  );

  // Handshake: accept only when idle, unstalled, out of reset and not flushed.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && !stall && !rst;
    accept   = in_valid && in_ready && !flush;
  end

  // Next-state for the EX/MEM registers and the redirect FSM.
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    wr_en_d       = wr_en_q;
    wr_reg_d      = wr_reg_q;
    flag_bits_d   = flag_bits_q;
    redirect_pc_d = redirect_pc_q;

    // Flush overrides stall; stall otherwise freezes the whole entry.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (!stall) begin
      if (accept) begin
        out_valid_d = 1'b1;
        result_d    = ev_result;
        wr_en_d     = wr_en_in && !ev_is_branch;
        wr_reg_d    = wr_reg_in;
        flag_bits_d = {zf, sf, of, cf};
      end else begin
        out_valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && ev_is_branch && ev_taken) begin
          state_d       = ST_PEND;
          redirect_pc_d = br_target;
        end
      end
      ST_PEND: begin
        if (flush || redirect_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_reg_q      <= '0;
      flag_bits_q   <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      wr_en_q       <= wr_en_d;
      wr_reg_q      <= wr_reg_d;
      flag_bits_q   <= flag_bits_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign result         = result_q;
  assign wr_en          = wr_en_q && out_valid_q;
  assign wr_reg         = wr_reg_q;
  assign flags_q        = flag_bits_q;
  assign redirect_valid = (state_q == ST_PEND);
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_alu_cond_resolve.sv
// Directed testbench for alu_cond_resolve.
module tb_alu_cond_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [3:0]  cond_op;
  logic [15:0] alu_out;
  logic        zf, sf, of, cf;
  logic [15:0] br_target;
  logic        wr_en_in;
  logic [2:0]  wr_reg_in;
  logic        out_valid;
  logic [15:0] result;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [3:0]  flags_q;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        redirect_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_cond_resolve #(
    .DATA_WIDTH (16),
    .REG_ADDR_W (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .stall          (stall),
    .flush          (flush),
    .cond_op        (cond_op),
    .alu_out        (alu_out),
    .zf             (zf),
    .sf             (sf),
    .of             (of),
    .cf             (cf),
    .br_target      (br_target),
    .wr_en_in       (wr_en_in),
    .wr_reg_in      (wr_reg_in),
    .out_valid      (out_valid),
    .result         (result),
    .wr_en          (wr_en),
    .wr_reg         (wr_reg),
    .flags_q        (flags_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic z, input logic s, input logic o, input logic c,
                        input logic [15:0] tgt, input logic we, input logic [2:0] wreg);
    in_valid  = v;
    cond_op   = op;
    alu_out   = a;
    zf        = z;
    sf        = s;
    of        = o;
    cf        = c;
    br_target = tgt;
    wr_en_in  = we;
    wr_reg_in = wreg;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_ack = 1'b0;
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    step(); step();
    tests_run++;
    if ({out_valid, result, wr_en, wr_reg, flags_q, redirect_valid, redirect_pc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ov=%0b res=%h we=%0b wr=%0d fl=%b rv=%0b pc=%h required all 0",
               out_valid, result, wr_en, wr_reg, flags_q, redirect_valid, redirect_pc);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_slt();
    set_in(1'b1, 4'd2, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 3'd3);
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({out_valid, result, wr_en, wr_reg, flags_q} !== {1'b1, 16'h0001, 1'b1, 3'd3, 4'b0010}) begin
      tests_failed++;
      $display("FAIL slt_capture: got ov=%0b res=%h we=%0b wr=%0d fl=%b required ov=1 res=0001 we=1 wr=3 fl=0010",
               out_valid, result, wr_en, wr_reg, flags_q);
    end
    step();
    tests_run++;
    if ({out_valid, wr_en} !== 2'b00) begin
      tests_failed++;
      $display("FAIL slt_pulse: got ov=%0b we=%0b required ov=0 we=0", out_valid, wr_en);
    end
  endtask

  task automatic test_set_conds();
    // Back-to-back accepts: SLE true via zf, SLE false (sf^of=0), SCO carry, NONE pass-through.
    set_in(1'b1, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd1);
    step();
    tests_run++;
    if ({out_valid, result} !== {1'b1, 16'h0001}) begin
      tests_failed++;
      $display("FAIL sle_zero: got ov=%0b res=%h required ov=1 res=0001", out_valid, result);
    end
    set_in(1'b1, 4'd3, 16'h8001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 3'd2);
    step();
    tests_run++;
    if ({out_valid, result, flags_q} !== {1'b1, 16'h0000, 4'b0110}) begin
      tests_failed++;
      $display("FAIL sle_false: got ov=%0b res=%h fl=%b required ov=1 res=0000 fl=0110", out_valid, result, flags_q);
    end
    set_in(1'b1, 4'd4, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1, 3'd4);
    step();
    tests_run++;
    if ({out_valid, result, wr_reg} !== {1'b1, 16'h0001, 3'd4}) begin
      tests_failed++;
      $display("FAIL sco_carry: got ov=%0b res=%h wr=%0d required ov=1 res=0001 wr=4", out_valid, result, wr_reg);
    end
    set_in(1'b1, 4'd0, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 3'd6);
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({out_valid, result, wr_en, wr_reg} !== {1'b1, 16'hBEEF, 1'b0, 3'd6}) begin
      tests_failed++;
      $display("FAIL none_pass: got ov=%0b res=%h we=%0b wr=%0d required ov=1 res=beef we=0 wr=6",
               out_valid, result, wr_en, wr_reg);
    end
    step();
  endtask

  task automatic test_branch_taken();
    set_in(1'b1, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 3'd5);
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({redirect_valid, redirect_pc, in_ready, out_valid, wr_en, result} !== {1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL beqz_redirect: got rv=%0b pc=%h rdy=%0b ov=%0b we=%0b res=%h required rv=1 pc=0040 rdy=0 ov=1 we=0 res=0000",
               redirect_valid, redirect_pc, in_ready, out_valid, wr_en, result);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      br_target = 16'h0099;
      step();
      tests_run++;
      if ({redirect_valid, redirect_pc, in_ready, out_valid} !== {1'b1, 16'h0040, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL beqz_hold%0d: got rv=%0b pc=%h rdy=%0b ov=%0b required rv=1 pc=0040 rdy=0 ov=0",
                 i, redirect_valid, redirect_pc, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    tests_run++;
    if ({redirect_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL beqz_ack: got rv=%0b rdy=%0b required rv=0 rdy=1", redirect_valid, in_ready);
    end
  endtask

  task automatic test_branch_not_taken();
    set_in(1'b1, 4'd9, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b1, 3'd2);
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({out_valid, wr_en, redirect_valid, in_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL bnez_not_taken: got ov=%0b we=%0b rv=%0b rdy=%0b required ov=1 we=0 rv=0 rdy=1",
               out_valid, wr_en, redirect_valid, in_ready);
    end
    step();
    tests_run++;
    if ({redirect_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bnez_after: got rv=%0b rdy=%0b required rv=0 rdy=1", redirect_valid, in_ready);
    end
    // BGEZ with sf=0 is taken; ack while still idle beforehand must be ignored.
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    tests_run++;
    if ({redirect_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ack_idle: got rv=%0b rdy=%0b required rv=0 rdy=1", redirect_valid, in_ready);
    end
    set_in(1'b1, 4'd11, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0);
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 16'h1230}) begin
      tests_failed++;
      $display("FAIL bgez_taken: got rv=%0b pc=%h required rv=1 pc=1230", redirect_valid, redirect_pc);
    end
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_flush_pend();
    set_in(1'b1, 4'd10, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0088, 1'b0, 3'd0);
    step();
    tests_run++;
    if (redirect_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bltz_taken: got rv=%0b required 1", redirect_valid);
    end
    flush = 1'b1;
    redirect_ack = 1'b1;
    step();
    flush = 1'b0;
    redirect_ack = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if ({redirect_valid, out_valid, in_ready, flags_q} !== {1'b0, 1'b0, 1'b1, 4'b0100}) begin
      tests_failed++;
      $display("FAIL flush_pend: got rv=%0b ov=%0b rdy=%0b fl=%b required rv=0 ov=0 rdy=1 fl=0100",
               redirect_valid, out_valid, in_ready, flags_q);
    end
    // Flush beats a simultaneous accept.
    set_in(1'b1, 4'd0, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, 3'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({out_valid, flags_q} !== {1'b0, 4'b0100} || result === 16'h5555) begin
      tests_failed++;
      $display("FAIL flush_accept: got ov=%0b fl=%b res=%h required ov=0 fl=0100 res!=5555",
               out_valid, flags_q, result);
    end
  endtask

  task automatic test_stall();
    set_in(1'b1, 4'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd5);
    step();
    tests_run++;
    if ({out_valid, result} !== {1'b1, 16'h1234}) begin
      tests_failed++;
      $display("FAIL stall_setup: got ov=%0b res=%h required ov=1 res=1234", out_valid, result);
    end
    set_in(1'b1, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd6);
    stall = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_ready: got %0b required 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if ({out_valid, result, wr_en, wr_reg, flags_q} !== {1'b1, 16'h1234, 1'b1, 3'd5, 4'b0000}) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got ov=%0b res=%h we=%0b wr=%0d fl=%b required ov=1 res=1234 we=1 wr=5 fl=0000",
                 i, out_valid, result, wr_en, wr_reg, flags_q);
      end
    end
    stall = 1'b0;
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    tests_run++;
    if ({out_valid, result, wr_reg, flags_q} !== {1'b1, 16'h0001, 3'd6, 4'b1000}) begin
      tests_failed++;
      $display("FAIL stall_release: got ov=%0b res=%h wr=%0d fl=%b required ov=1 res=0001 wr=6 fl=1000",
               out_valid, result, wr_reg, flags_q);
    end
    step();
  endtask

  task automatic test_reset_pend();
    set_in(1'b1, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00F0, 1'b0, 3'd0);
    step();
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({redirect_valid, redirect_pc, out_valid, flags_q, in_ready} !== {1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_pend: got rv=%0b pc=%h ov=%0b fl=%b rdy=%0b required rv=0 pc=0000 ov=0 fl=0000 rdy=1",
               redirect_valid, redirect_pc, out_valid, flags_q, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_slt();
    test_set_conds();
    test_branch_taken();
    test_branch_not_taken();
    test_flush_pend();
    test_stall();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
